wb_stream_fifo_slave: RTL

// - Parametrised Wishbone B3 slave giving DMA masters such as sdc_controller a FIFO-backed endpoint, in place of a flat RAM.
// - Write path: WB writes push into a TX FIFO, which drains to a valid/ready stream (m_*).
// - Read path: a valid/ready stream (s_*) fills an RX FIFO, which WB reads pop.
// - Sits behind wb_mux as a slave; supports classic and incrementing-burst cycles, wait states, a status/flush register and a timeout error.

---
 rtl/wb_fifo_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 48 ++++
 rtl/wb_stream_fifo_slave.sv | 135 +++++++++++++
 3 files changed

// File: rtl/wb_fifo_pkg.sv
// rtl/wb_fifo_pkg.sv - shared codes and beat-state type for the Wishbone stream FIFO slave
package wb_fifo_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int FLUSH_TX = 0;
  localparam int FLUSH_RX = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } beat_state_e;

  // Constant-address bursts are handled exactly like incrementing ones.
  function automatic logic is_burst_cti(input logic [2:0] cti);
    return (cti == CTI_INCR) || (cti == CTI_CONST);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO with flush and occupancy
module sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit, so level reaches DEPTH only when its MSB is set.
  assign level   = wr_ptr - rd_ptr;
  assign full    = level[PW];
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_stream_fifo_slave.sv
// rtl/wb_stream_fifo_slave.sv - Wishbone B3 slave: DATA writes feed a TX stream, DATA reads drain an RX stream
module wb_stream_fifo_slave #(
  parameter int DW      = 32,
  parameter int DEPTH   = 512,
  parameter int AW      = 32,
  parameter int TIMEOUT = 0
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  input  logic [2:0]      wb_cti_i,
  input  logic [1:0]      wb_bte_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            m_valid_o,
  output logic [DW-1:0]   m_data_o,
  input  logic            m_ready_i,
  input  logic            s_valid_i,
  input  logic [DW-1:0]   s_data_i,
  output logic            s_ready_o,
  output logic [15:0]     tx_level_o,
  output logic [15:0]     rx_level_o
);

  import wb_fifo_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic [LW-1:0] tx_lvl;
  logic [LW-1:0] rx_lvl;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [DW-1:0] rx_dout;

  beat_state_e   state;
  logic          in_burst;
  logic          ready_en;
  logic [31:0]   tmo_cnt;

  logic          is_status, burst_cti, cont_ok, req, bad_sel, can_go;
  logic          perform, timed_out;
  logic          tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;
  logic [31:0]   status_word;
  logic          unused_ok;

  assign is_status = (wb_adr_i[2] == REG_STATUS);
  assign burst_cti = is_burst_cti(wb_cti_i);
  // An end-of-burst beat only rides on the previous ack when it closes a running burst.
  assign cont_ok   = burst_cti | ((wb_cti_i == CTI_EOB) & in_burst);
  assign req       = wb_cyc_i & wb_stb_i & ~wb_err_o & ((state != ST_RESP) | cont_ok);

  assign bad_sel   = wb_we_i & ~is_status & (wb_sel_i != {(DW/8){1'b1}});
  assign can_go    = is_status | bad_sel | (wb_we_i ? ~tx_full : ~rx_empty);
  assign perform   = req & can_go;
  assign timed_out = (TIMEOUT != 0) & req & ~can_go & (tmo_cnt == 32'(TIMEOUT - 1));

  assign tx_push  = perform & wb_we_i & ~is_status & ~bad_sel;
  assign tx_pop   = m_valid_o & m_ready_i;
  assign tx_flush = perform & wb_we_i & is_status & wb_dat_i[FLUSH_TX];
  assign rx_pop   = perform & ~wb_we_i & ~is_status;
  assign rx_flush = perform & wb_we_i & is_status & wb_dat_i[FLUSH_RX];

  assign s_ready_o = ready_en & ~rx_full & ~rx_flush;
  assign rx_push   = s_valid_i & s_ready_o;
  assign m_valid_o = ~tx_empty;

  assign tx_level_o  = 16'(tx_lvl);
  assign rx_level_o  = 16'(rx_lvl);
  assign status_word = {rx_level_o, tx_level_o};

  assign unused_ok = &{1'b0, wb_bte_i, wb_adr_i[AW-1:3], wb_adr_i[1:0]};

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (wb_dat_i),
    .dout  (m_data_o),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_lvl)
  );

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (s_data_i),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_lvl)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      tmo_cnt  <= '0;
      in_burst <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      wb_ack_o <= perform & ~bad_sel;
      wb_err_o <= (perform & bad_sel) | timed_out;

      if (perform & ~wb_we_i) begin
        wb_dat_o <= is_status ? DW'(status_word) : rx_dout;
      end

      if (perform || timed_out) state <= ST_RESP;
      else if (req)             state <= ST_WAIT;
      else                      state <= ST_IDLE;

      // Counts wait cycles of the pending beat only; any response or dropped cycle restarts it.
      if (!wb_cyc_i || perform || timed_out) tmo_cnt <= '0;
      else if (req)                          tmo_cnt <= tmo_cnt + 32'd1;

      if (!wb_cyc_i)    in_burst <= 1'b0;
      else if (perform) in_burst <= burst_cti;
    end
  end

endmodule
